xillybus_mem8_responder: RTL

User-side responder for the Xillybus seekable 8-bit stream `mem_8`: it owns a 32-byte dual-port memory that the host reads and writes through the core's `user_r_mem_8_*`, `user_w_mem_8_*` and `user_mem_8_addr*` signals. A second port lets on-chip application logic read and write the same bytes, so the block works as a host↔fabric mailbox. It sits in the `bus_clk` domain directly beside `xillybus_core`. After reset it clears its contents with an internal sweep.

---
 rtl/xillybus_mem8_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xillybus_mem8_responder.sv
// Host <-> fabric byte mailbox behind the Xillybus seekable stream mem_8.
// Ports: bus_clk/bus_rst; host user_r_mem_8_* (read), user_w_mem_8_* (write),
//        user_mem_8_addr* (seek); app_* second port; host_wr_pending/count flags.
// Latency: host and app reads 1 cycle (read-first); writes commit at the strobe edge.
// Backpressure: empty/full held high for the 2^DEPTH_LOG2-cycle clear sweep, otherwise never.
module xillybus_mem8_responder #(
    parameter int DEPTH_LOG2     = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic                  user_r_mem_8_rden,
    output logic [7:0]            user_r_mem_8_data,
    output logic                  user_r_mem_8_empty,
    output logic                  user_r_mem_8_eof,
    input  logic                  user_r_mem_8_open,
    input  logic                  user_w_mem_8_wren,
    input  logic [7:0]            user_w_mem_8_data,
    output logic                  user_w_mem_8_full,
    input  logic                  user_w_mem_8_open,
    input  logic [DEPTH_LOG2-1:0] user_mem_8_addr,
    input  logic                  user_mem_8_addr_update,
    input  logic [DEPTH_LOG2-1:0] app_addr,
    input  logic                  app_we,
    input  logic [7:0]            app_wr_data,
    output logic [7:0]            app_rd_data,
    output logic                  host_wr_pending,
    output logic [7:0]            host_wr_count,
    input  logic                  app_ack
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic                  state;
    logic [DEPTH_LOG2-1:0] clr_ptr;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [7:0]            mem [DEPTH];

    logic run;
    logic host_we;
    logic host_re;
    logic app_wr;
    logic seek;
    logic clr_last;
    logic app_blocked;

    // The open strobes carry no control meaning: closing a file keeps ptr and contents.
    logic unused_opens;
    assign unused_opens = user_r_mem_8_open ^ user_w_mem_8_open;

    // All user-side strobes are ignored while the sweep owns the memory.
    assign run         = (state == ST_RUN);
    assign host_we     = run & user_w_mem_8_wren;
    assign host_re     = run & user_r_mem_8_rden;
    assign app_wr      = run & app_we;
    assign seek        = run & user_mem_8_addr_update;
    assign clr_last    = (clr_ptr == DEPTH_LOG2'(DEPTH - 1));
    // Host data wins a same-address write collision.
    assign app_blocked = host_we & (app_addr == ptr);

    assign user_r_mem_8_empty = ~run;
    assign user_w_mem_8_full  = ~run;
    assign user_r_mem_8_eof   = 1'b0;

    // Control FSM and clear pointer.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + DEPTH_LOG2'(1);
            if (clr_last) begin
                state <= ST_RUN;
            end
        end
    end

    // Shared host address: a seek beats the post-access increment, and one
    // increment covers a simultaneous read and write.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            ptr <= '0;
        end else if (seek) begin
            ptr <= user_mem_8_addr;
        end else if (host_we || host_re) begin
            ptr <= ptr + DEPTH_LOG2'(1);
        end
    end

    // Memory array: not reset, so contents survive when the sweep is disabled.
    always_ff @(posedge bus_clk) begin
        if (!bus_rst) begin
            if (!run) begin
                mem[clr_ptr] <= 8'h00;
            end else begin
                if (app_wr && !app_blocked) begin
                    mem[app_addr] <= app_wr_data;
                end
                if (host_we) begin
                    mem[ptr] <= user_w_mem_8_data;
                end
            end
        end
    end

    // Registered read ports; sampling mem here returns pre-write (old) data.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            user_r_mem_8_data <= 8'h00;
            app_rd_data       <= 8'h00;
        end else begin
            app_rd_data <= mem[app_addr];
            if (host_re) begin
                user_r_mem_8_data <= mem[ptr];
            end
        end
    end

    // Host-write flags; a host write in the same cycle as app_ack keeps pending set.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            host_wr_count   <= 8'h00;
            host_wr_pending <= 1'b0;
        end else if (host_we) begin
            host_wr_count   <= host_wr_count + 8'd1;
            host_wr_pending <= 1'b1;
        end else if (app_ack) begin
            host_wr_pending <= 1'b0;
        end
    end

endmodule
